fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of the 16-deep, 8-bit FIFO controller between NUM_REQ independent producers.
- Round-robin arbitration with burst locking: once granted, a producer keeps the port for up to MAX_BURST beats.
- Outputs are registered and drive the FIFO's write_en/data_in directly.
- Uses the FIFO's full/almost_full flags so no accepted beat is ever dropped.

Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 8, beat width; must match the FIFO data width
- MAX_BURST, 4, max beats per grant (>=1)
- ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-producer valid; held with data until acked
- req_data  in  NUM_REQ*DATA_W  producer i data at [i*DATA_W +: DATA_W]
- req_ack  out  NUM_REQ  combinational one-hot; beat of producer i accepted this cycle
- fifo_full  in  1  FIFO full flag
- fifo_almost_full  in  1  FIFO almost_full flag (count 14..15)
- fifo_write_en  out  1  registered write strobe to FIFO
- fifo_data_in  out  DATA_W  registered write data to FIFO
- grant_valid  out  1  registered; arbiter in OWNED state
- grant_id  out  ID_W  registered; current owner index

Behaviour:
- Reset (sync, at the edge with reset=1):
  - state=ARB_IDLE; grant_valid=0; grant_id=0; fifo_write_en=0; fifo_data_in=0; beat_cnt=0; last_owner=NUM_REQ-1.
  - req_ack=0 while in ARB_IDLE.
  - Reset mid-burst discards the grant. Any beat already acked was written or is being written that cycle; no beat is duplicated.
- accept_ok = !fifo_full && !(fifo_write_en && fifo_almost_full).
  - This accounts for the one write in flight, so the FIFO count never exceeds 16 and no write is dropped.
  - The rule is conservative: with count 14 and a write pending, acceptance stalls one cycle.
- State machine, ARB_IDLE:
  - If any req bit is set, select the first set bit searching last_owner+1, +2, ... modulo NUM_REQ.
  - Next cycle: state=ARB_OWNED, grant_id=sel, grant_valid=1, beat_cnt=0.
  - No ack is issued in ARB_IDLE.
- State machine, ARB_OWNED:
  - req_ack[grant_id] = req[grant_id] && accept_ok; all other ack bits are 0.
  - On ack: fifo_data_in <= req_data[grant_id]; fifo_write_en <= 1 (next cycle); beat_cnt++.
  - With no ack, fifo_write_en <= 0.
- Release to ARB_IDLE (last_owner <= grant_id, grant_valid <= 0) when either:
  - ack && beat_cnt==MAX_BURST-1, or
  - !req[grant_id] (owner drops mid-burst, no ack that cycle).
- Stall: fifo_full or almost_full blocking holds ARB_OWNED indefinitely; beat_cnt and data are frozen. Lower-priority producers wait; there is no timeout.
- Latency: ack cycle N → fifo_write_en=1 in cycle N+1 → FIFO stores at end of N+1.
- Throughput: MAX_BURST beats per MAX_BURST+1 cycles (one arbitration bubble per grant).
- Fairness: a continuously requesting producer waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles after its competitors' grants begin.
- Widths: beat_cnt is max(1,$clog2(MAX_BURST)) bits and wraps only via release. last_owner+k uses mod-NUM_REQ arithmetic, so no out-of-range index for non-power-of-2 NUM_REQ.
- Simultaneous events:
  - Release and a new request in the same cycle: re-arbitration happens in the following ARB_IDLE cycle.
  - req deasserted in the cycle fifo_full rises: treated as release.

Decomposition:
- Package fifo_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_OWNED}; default DATA_W=8, NUM_REQ=4, MAX_BURST=4; FIFO_DEPTH=16.
- Sub-module rr_pick (combinational): inputs req, last_owner; outputs sel (ID_W), any. Instantiated once.

Test Plan:
- After reset, req=4'b0101 held continuously, FIFO empty and draining → grant 0 for 4 beats, bubble, grant 2 for 4 beats, then 0 again. fifo_write_en shows 4 highs per 5 cycles and data order matches.
- Only req[3] set with MAX_BURST=4, 10 beats 0x30..0x39, no reads → 10 writes in order, 3 grants (4,4,2 beats).
- FIFO fill with no reads: continuous writes from req[1] → exactly 16 beats acked. req_ack stays low once fifo_full=1 (or the pending write hits count 16); FIFO contents 16 unique values, none lost.
- Owner 2 drops req after 2 beats while req[0]=1 → release after beat 2, one IDLE cycle, then grant_id=0. last_owner=2, so req[3] asserted later wins ahead of 0.
- Reset asserted in the middle of a burst (beat 2 of 4) → next cycle grant_valid=0, fifo_write_en=0, fifo_data_in=0. After release, req=4'b1111 grants producer 0 first.
- Stall: fifo_full held 5 cycles mid-burst → req_ack=0 and grant_id unchanged throughout. After fifo_full drops, the burst resumes with the remaining beat count.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter slice.
// The arbiter only ever owns the port or waits to hand it out, hence two states.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_NUM_REQ   = 4;
    localparam int DEFAULT_MAX_BURST = 4;
    localparam int FIFO_DEPTH        = 16;

    // Beat counter never collapses to zero width, even for single-beat bursts.
    function automatic int beat_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side request/ack lanes plus the FIFO write port, bundled as one bus.
// slave is the arbiter's view; master is the producers/FIFO view.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      fifo_full;
    logic                      fifo_almost_full;
    logic                      fifo_write_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;

    modport slave (
        input  req, req_data, fifo_full, fifo_almost_full,
        output req_ack, fifo_write_en, fifo_data_in, grant_valid, grant_id
    );

    modport master (
        output req, req_data, fifo_full, fifo_almost_full,
        input  req_ack, fifo_write_en, fifo_data_in, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin selector: first set request after last_owner, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic [ID_W-1:0]    sel,
    output logic               any
);
    function automatic logic [ID_W-1:0] ring_idx(input logic [ID_W-1:0] base, input int k);
        return ID_W'((int'(base) + k) % NUM_REQ);
    endfunction

    always_comb begin
        sel = '0;
        any = |req;
        // Walk the ring from farthest to nearest so the nearest requester is written last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[ring_idx(last_owner, k)]) begin
                sel = ring_idx(last_owner, k);
            end
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port between NUM_REQ producers.
// Write strobe and data are registered; acceptance accounts for the write in flight.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEFAULT_NUM_REQ,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                reset,
    fifo_write_arbiter_if.slave bus
);
    localparam int                BEAT_W    = beat_width(MAX_BURST);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_t        state_reg, state_next;
    logic              grant_valid_reg, grant_valid_next;
    logic [ID_W-1:0]   grant_id_reg, grant_id_next;
    logic [ID_W-1:0]   last_owner_reg, last_owner_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic              write_en_reg, write_en_next;
    logic [DATA_W-1:0] data_reg, data_next;

    logic [DATA_W-1:0]  req_words [NUM_REQ];
    logic [ID_W-1:0]    pick_sel;
    logic               pick_any;
    logic               accept_ok;
    logic               owner_req;
    logic               ack;
    logic [NUM_REQ-1:0] ack_vec;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_words[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
        .req        (bus.req),
        .last_owner (last_owner_reg),
        .sel        (pick_sel),
        .any        (pick_any)
    );

    // A pending write plus almost_full could still reach full, so hold off one beat.
    assign accept_ok = !bus.fifo_full && !(write_en_reg && bus.fifo_almost_full);
    assign owner_req = bus.req[grant_id_reg];
    assign ack       = (state_reg == ARB_OWNED) && owner_req && accept_ok && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ARB_IDLE;
            grant_valid_reg <= 1'b0;
            grant_id_reg    <= '0;
            last_owner_reg  <= LAST_ID;
            beat_cnt_reg    <= '0;
            write_en_reg    <= 1'b0;
            data_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            grant_valid_reg <= grant_valid_next;
            grant_id_reg    <= grant_id_next;
            last_owner_reg  <= last_owner_next;
            beat_cnt_reg    <= beat_cnt_next;
            write_en_reg    <= write_en_next;
            data_reg        <= data_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_valid_next = grant_valid_reg;
        grant_id_next    = grant_id_reg;
        last_owner_next  = last_owner_reg;
        beat_cnt_next    = beat_cnt_reg;
        write_en_next    = 1'b0;
        data_next        = data_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next       = ARB_OWNED;
                    grant_id_next    = pick_sel;
                    grant_valid_next = 1'b1;
                    beat_cnt_next    = '0;
                end
            end
            ARB_OWNED: begin
                if (ack) begin
                    write_en_next = 1'b1;
                    data_next     = req_words[grant_id_reg];
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
                // Burst exhausted or owner walked away; a stall alone never releases.
                if ((ack && beat_cnt_reg == LAST_BEAT) || !owner_req) begin
                    state_next       = ARB_IDLE;
                    grant_valid_next = 1'b0;
                    last_owner_next  = grant_id_reg;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        ack_vec = '0;
        if (ack) begin
            ack_vec[grant_id_reg] = 1'b1;
        end
    end

    assign bus.req_ack       = ack_vec;
    assign bus.fifo_write_en = write_en_reg;
    assign bus.fifo_data_in  = data_reg;
    assign bus.grant_valid   = grant_valid_reg;
    assign bus.grant_id      = grant_id_reg;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised bench: producer queues feed the arbiter, a FIFO model sinks writes,
// and a monitor checks every write against a round-robin-over-queues reference order.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus();

    fifo_write_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    logic [DATA_W-1:0] prod_q [NUM_REQ][$];
    logic [DATA_W-1:0] exp_q [$];
    int  rd_pct       = 100;
    bit  force_full   = 1'b0;
    bit  sb_en        = 1'b0;
    int  fifo_count   = 0;
    int  wr_total     = 0;
    int  ack_total    = 0;
    int  last_owner_m = NUM_REQ - 1;

    assign bus.fifo_full        = (fifo_count == FIFO_DEPTH) || force_full;
    assign bus.fifo_almost_full = (fifo_count >= FIFO_DEPTH - 2) && (fifo_count < FIFO_DEPTH);

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Producers: hold front-of-queue until acked, pop after the accepting edge.
    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        forever begin
            logic [NUM_REQ-1:0]        ack_s;
            logic [NUM_REQ-1:0]        req_v;
            logic [NUM_REQ*DATA_W-1:0] data_v;
            @(negedge clk);
            ack_s = bus.req_ack;
            if (ack_s != '0) begin
                ack_total++;
                check_eq("ack_onehot_to_requester",
                         {31'b0, $onehot(ack_s) && ((ack_s & ~bus.req) == '0)}, 32'd1);
            end
            @(posedge clk);
            #1;
            req_v  = '0;
            data_v = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_s[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
                if (prod_q[i].size() > 0) begin
                    req_v[i]                  = 1'b1;
                    data_v[i*DATA_W +: DATA_W] = prod_q[i][0];
                end
            end
            bus.req      = req_v;
            bus.req_data = data_v;
        end
    end

    // FIFO model: stores on write_en, drains at rd_pct percent per cycle.
    always @(posedge clk) begin
        int nxt;
        nxt = fifo_count;
        if (reset) begin
            nxt = 0;
        end else begin
            if (bus.fifo_write_en) begin
                check_eq("fifo_no_overflow", {31'b0, fifo_count < FIFO_DEPTH}, 32'd1);
                if (fifo_count < FIFO_DEPTH) nxt++;
            end
            if (fifo_count > 0 && int'($urandom_range(0, 99)) < rd_pct) nxt--;
        end
        fifo_count <= nxt;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && bus.fifo_write_en) begin
            wr_total++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("FAIL sb_write_order: got unexpected write 0x%02h, required no write",
                             bus.fifo_data_in);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    $display("write %0d data=0x%02h expected=0x%02h", wr_total, bus.fifo_data_in, e);
                    check_eq("sb_write_order", {24'b0, bus.fifo_data_in}, {24'b0, e});
                end
            end else begin
                $display("write %0d data=0x%02h (unscored)", wr_total, bus.fifo_data_in);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit prod_empty();
        for (int i = 0; i < NUM_REQ; i++) if (prod_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) prod_q[i].delete();
        repeat (3) @(posedge clk);
        #1;
        reset        = 1'b0;
        last_owner_m = NUM_REQ - 1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 3000 && !(prod_empty() && exp_q.size() == 0 && !bus.grant_valid
                             && !bus.fifo_write_en && fifo_count == 0)) begin
            @(posedge clk);
            n++;
        end
        check_eq(name, {31'b0, n < 3000}, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_acks(input int who, input int n, input string name);
        int seen, cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 200) begin
            @(negedge clk);
            if (bus.req_ack[who]) seen++;
            cyc++;
        end
        check_eq(name, seen, n);
    endtask

    // Reference: grants rotate over non-empty producer queues, each taking up to MAX_BURST.
    task automatic run_phase(input int cnt [NUM_REQ], input int pct);
        logic [DATA_W-1:0] items [NUM_REQ][$];
        int taken [NUM_REQ];
        int left;
        rd_pct = pct;
        left   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            taken[i] = 0;
            left += cnt[i];
            for (int j = 0; j < cnt[i]; j++) items[i].push_back(DATA_W'($urandom));
        end
        while (left > 0) begin
            int o, b;
            o = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (last_owner_m + k) % NUM_REQ;
                if (o < 0 && taken[c] < cnt[c]) o = c;
            end
            b = (cnt[o] - taken[o] < MAX_BURST) ? cnt[o] - taken[o] : MAX_BURST;
            for (int j = 0; j < b; j++) exp_q.push_back(items[o][taken[o] + j]);
            taken[o] += b;
            left     -= b;
            last_owner_m = o;
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < NUM_REQ; i++)
            foreach (items[i][j]) prod_q[i].push_back(items[i][j]);
        wait_idle("phase_completes");
    endtask

    initial begin
        int ack0, wr0, gcyc;
        int cnt [NUM_REQ];

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_grant_valid", {31'b0, bus.grant_valid}, 32'd0);
        check_eq("reset_grant_id", {30'b0, bus.grant_id}, 32'd0);
        check_eq("reset_write_en", {31'b0, bus.fifo_write_en}, 32'd0);
        check_eq("reset_data_in", {24'b0, bus.fifo_data_in}, 32'd0);
        check_eq("reset_req_ack", {28'b0, bus.req_ack}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset in the middle of a burst by producer 2.
        @(posedge clk);
        #2;
        for (int j = 0; j < 4; j++) prod_q[2].push_back(DATA_W'(8'h20 + j));
        wait_acks(2, 2, "midburst_two_acks");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) prod_q[i].delete();
        @(negedge clk);
        check_eq("midburst_ack_during_reset", {28'b0, bus.req_ack}, 32'd0);
        check_eq("midburst_beat2_in_flight", {31'b0, bus.fifo_write_en}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("after_reset_grant_valid", {31'b0, bus.grant_valid}, 32'd0);
        check_eq("after_reset_write_en", {31'b0, bus.fifo_write_en}, 32'd0);
        check_eq("after_reset_data_in", {24'b0, bus.fifo_data_in}, 32'd0);
        @(posedge clk);
        #2;
        for (int i = 0; i < NUM_REQ; i++) prod_q[i].push_back(DATA_W'(8'h40 + i));
        gcyc = 0;
        while (!bus.grant_valid && gcyc < 20) begin
            @(negedge clk);
            gcyc++;
        end
        check_eq("after_reset_first_grant", {30'b0, bus.grant_id}, 32'd0);
        wait_idle("after_reset_drain");

        // Stall: fifo_full forced for 5 cycles after beat 2 of producer 1.
        do_reset();
        @(posedge clk);
        #2;
        for (int j = 0; j < 4; j++) prod_q[1].push_back(DATA_W'(8'h10 + j));
        wait_acks(1, 2, "stall_two_acks");
        @(posedge clk);
        #1;
        force_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_no_ack", {28'b0, bus.req_ack}, 32'd0);
            check_eq("stall_grant_id", {30'b0, bus.grant_id}, 32'd1);
            check_eq("stall_grant_valid", {31'b0, bus.grant_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        force_full = 1'b0;
        gcyc = 0;
        ack0 = 0;
        do begin
            @(negedge clk);
            if (bus.req_ack[1]) ack0++;
            gcyc++;
        end while (bus.grant_valid && gcyc < 30);
        check_eq("stall_remaining_beats", ack0, 2);
        wait_idle("stall_drain");

        // Scored traffic from a fresh reset.
        do_reset();
        sb_en = 1'b1;
        cnt = '{8, 0, 8, 0};
        run_phase(cnt, 100);
        cnt = '{0, 0, 0, 10};
        run_phase(cnt, 100);

        // Fill with no reads: only 16 beats may be accepted.
        ack0   = ack_total;
        wr0    = wr_total;
        rd_pct = 0;
        @(posedge clk);
        #2;
        for (int j = 0; j < 20; j++) begin
            prod_q[1].push_back(DATA_W'(8'h80 + j));
            exp_q.push_back(DATA_W'(8'h80 + j));
        end
        repeat (80) @(posedge clk);
        @(negedge clk);
        check_eq("fill_acks", ack_total - ack0, 16);
        check_eq("fill_writes", wr_total - wr0, 16);
        check_eq("fill_fifo_count", fifo_count, FIFO_DEPTH);
        check_eq("fill_no_ack_when_full", {28'b0, bus.req_ack}, 32'd0);
        last_owner_m = 1;
        rd_pct = 60;
        wait_idle("fill_drain");

        for (int p = 0; p < 30; p++) begin
            int pct;
            for (int i = 0; i < NUM_REQ; i++) cnt[i] = int'($urandom_range(0, 6));
            cnt[$urandom_range(0, NUM_REQ - 1)] += 1;
            case ($urandom_range(0, 2))
                0:       pct = 5;
                1:       pct = 30;
                default: pct = 100;
            endcase
            run_phase(cnt, pct);
        end

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
